// File: rtl/scr_ndim_core_if.sv
// Handshake and control bundle for scr_ndim_core: data in/out with valid/ready,
// mode and seed controls, and the debug view of the LFSR state.
interface scr_ndim_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SCR_WIDTH  = 7
);
    logic                  scr_en;
    logic [1:0]            scr_mode;
    logic [SCR_WIDTH-1:0]  init_val;
    logic                  init_val_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_en;
    logic                  data_in_rdy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_en;
    logic                  data_out_rdy;
    logic [SCR_WIDTH-1:0]  scr_state;

    modport master (
        output scr_en, scr_mode, init_val, init_val_en,
        output data_in, data_in_en, data_out_rdy,
        input  data_in_rdy, data_out, data_out_en, scr_state
    );

    modport slave (
        input  scr_en, scr_mode, init_val, init_val_en,
        input  data_in, data_in_en, data_out_rdy,
        output data_in_rdy, data_out, data_out_en, scr_state
    );
endinterface

// File: rtl/scr_ndim_core.sv
// Parallel LFSR scrambler/descrambler: DATA_WIDTH bits per beat, additive or
// self-synchronising multiplicative modes, one registered valid/ready output stage.
module scr_ndim_core #(
    parameter int                   DATA_WIDTH = 8,
    parameter int                   SCR_WIDTH  = 7,
    parameter logic [SCR_WIDTH-1:0] POLY       = 7'h60
) (
    input  logic           clk,
    input  logic           kill,
    scr_ndim_core_if.slave bus
);

    logic [SCR_WIDTH-1:0]  r_state;
    logic [DATA_WIDTH-1:0] r_dout_p1;
    logic                  r_vld_p1;

    logic [1:0]            w_mode;
    logic [SCR_WIDTH-1:0]  w_seed;
    logic [SCR_WIDTH-1:0]  w_start;
    logic [SCR_WIDTH-1:0]  w_end;
    logic [DATA_WIDTH-1:0] w_scr;
    logic                  w_accept;

    // Bit 0 is the oldest bit, so the serial recurrence is unrolled from LSB upward.
    function automatic logic [SCR_WIDTH+DATA_WIDTH-1:0] f_scramble(
        input logic [SCR_WIDTH-1:0]  s_in,
        input logic [DATA_WIDTH-1:0] d_in,
        input logic [1:0]            mode
    );
        logic [SCR_WIDTH-1:0]  s;
        logic [DATA_WIDTH-1:0] d;
        logic                  fb;
        logic                  sh;
        s = s_in;
        d = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            fb   = ^(s & POLY);
            d[i] = d_in[i] ^ fb;
            case (mode)
                2'b01:   sh = d[i];
                2'b10:   sh = d_in[i];
                default: sh = fb;
            endcase
            s = {s[SCR_WIDTH-2:0], sh};
        end
        return {s, d};
    endfunction

    assign w_mode   = (bus.scr_mode == 2'b11) ? 2'b00 : bus.scr_mode;
    // An all-zero additive LFSR would lock up, so that seed is replaced by all ones.
    assign w_seed   = ((bus.init_val == '0) && (w_mode == 2'b00)) ? '1 : bus.init_val;
    assign w_start  = bus.init_val_en ? w_seed : r_state;
    assign {w_end, w_scr} = f_scramble(w_start, bus.data_in, w_mode);

    assign bus.data_in_rdy = !r_vld_p1 || bus.data_out_rdy;
    assign w_accept        = bus.data_in_en && bus.data_in_rdy;

    // p0 -> p1: accepted beat is scrambled and registered
    always_ff @(posedge clk) begin
        if (kill) begin
            r_state   <= '1;
            r_dout_p1 <= '0;
            r_vld_p1  <= 1'b0;
        end else if (w_accept) begin
            r_dout_p1 <= bus.scr_en ? w_scr : bus.data_in;
            r_state   <= bus.scr_en ? w_end : w_start;
            r_vld_p1  <= 1'b1;
        end else begin
            r_state <= w_start;
            if (r_vld_p1 && bus.data_out_rdy) begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.data_out    = r_dout_p1;
    assign bus.data_out_en = r_vld_p1;
    assign bus.scr_state   = r_state;

endmodule

// File: tb/tb_scr_ndim_core.sv
// Bench for scr_ndim_core: directed literals, randomized traffic against a serial
// LFSR reference model, and a scrambler->descrambler chain for round trip and self-sync.
module tb_scr_ndim_core;
    localparam int         DW   = 8;
    localparam int         SW   = 7;
    localparam logic [6:0] POLY = 7'h60;

    logic clk;
    logic kill;
    logic rt_kill;
    logic chk_en;

    scr_ndim_core_if #(.DATA_WIDTH(DW), .SCR_WIDTH(SW)) dut_if ();
    scr_ndim_core_if #(.DATA_WIDTH(DW), .SCR_WIDTH(SW)) rt_scr_if ();
    scr_ndim_core_if #(.DATA_WIDTH(DW), .SCR_WIDTH(SW)) rt_dsc_if ();

    scr_ndim_core #(.DATA_WIDTH(DW), .SCR_WIDTH(SW), .POLY(POLY)) u_dut (
        .clk(clk), .kill(kill), .bus(dut_if.slave));
    scr_ndim_core #(.DATA_WIDTH(DW), .SCR_WIDTH(SW), .POLY(POLY)) u_rt_scr (
        .clk(clk), .kill(rt_kill), .bus(rt_scr_if.slave));
    scr_ndim_core #(.DATA_WIDTH(DW), .SCR_WIDTH(SW), .POLY(POLY)) u_rt_dsc (
        .clk(clk), .kill(rt_kill), .bus(rt_dsc_if.slave));

    assign rt_dsc_if.data_in      = rt_scr_if.data_out;
    assign rt_dsc_if.data_in_en   = rt_scr_if.data_out_en;
    assign rt_scr_if.data_out_rdy = rt_dsc_if.data_in_rdy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one bit at a time, exactly as the line would see it serially.
    function automatic logic [14:0] ref_beat(input int st, input int din, input int mode);
        int s;
        int o;
        int fb;
        int ib;
        int ob;
        int sh;
        logic [31:0] sv;
        logic [31:0] ov;
        s = st;
        o = 0;
        for (int i = 0; i < DW; i++) begin
            fb = $countones(s & 32'(POLY)) % 2;
            ib = (din >> i) & 1;
            ob = ib ^ fb;
            if (mode == 1)      sh = ob;
            else if (mode == 2) sh = ib;
            else                sh = fb;
            o = o | (ob << i);
            s = ((s << 1) | sh) & 32'h7F;
        end
        sv = 32'(s);
        ov = 32'(o);
        return {sv[6:0], ov[7:0]};
    endfunction

    function automatic int seed_of(input int val, input int mode);
        if (val == 0 && (mode == 0 || mode == 3)) return 32'h7F;
        return val;
    endfunction

    logic [6:0]  m_state;
    logic [7:0]  m_dout;
    logic        m_vld;
    logic        m_acc;
    int          m_start;
    logic [14:0] m_res;

    always @(posedge clk) begin
        if (kill) begin
            m_state = 7'h7F;
            m_dout  = 8'h00;
            m_vld   = 1'b0;
        end else begin
            m_acc   = dut_if.data_in_en && (!m_vld || dut_if.data_out_rdy);
            m_start = dut_if.init_val_en ? seed_of(int'(dut_if.init_val), int'(dut_if.scr_mode))
                                         : int'(m_state);
            if (m_acc) begin
                if (dut_if.scr_en) begin
                    m_res   = ref_beat(m_start, int'(dut_if.data_in), int'(dut_if.scr_mode));
                    m_state = m_res[14:8];
                    m_dout  = m_res[7:0];
                end else begin
                    m_state = 7'(m_start);
                    m_dout  = dut_if.data_in;
                end
                m_vld = 1'b1;
            end else begin
                m_state = 7'(m_start);
                if (m_vld && dut_if.data_out_rdy) m_vld = 1'b0;
            end
        end
    end

    logic [7:0] rt_q[$];
    int         rt_sent = 0;
    int         rt_rcv  = 0;
    int         rt_skip = 0;
    logic [7:0] rt_exp;

    always @(negedge clk) begin
        if (chk_en) begin
            check("data_in_rdy", 32'(dut_if.data_in_rdy), 32'(!m_vld || dut_if.data_out_rdy));
            check("data_out_en", 32'(dut_if.data_out_en), 32'(m_vld));
            check("data_out", 32'(dut_if.data_out), 32'(m_dout));
            check("scr_state", 32'(dut_if.scr_state), 32'(m_state));
        end
        if (!rt_kill && rt_dsc_if.data_out_en && rt_dsc_if.data_out_rdy) begin
            if (rt_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rt_extra: got %0h expected no beat", rt_dsc_if.data_out);
            end else begin
                rt_exp = rt_q.pop_front();
                rt_rcv++;
                if (rt_skip > 0) rt_skip--;
                else check("rt_data", 32'(rt_dsc_if.data_out), 32'(rt_exp));
            end
        end
        if (!rt_kill && rt_scr_if.data_in_en && rt_scr_if.data_in_rdy) begin
            rt_q.push_back(rt_scr_if.data_in);
            rt_sent++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rt_run(input int beats);
        int guard;
        guard   = 0;
        rt_sent = 0;
        rt_rcv  = 0;
        while (rt_sent < beats && guard < 5000) begin
            rt_scr_if.data_in      = 8'($urandom);
            rt_scr_if.data_in_en   = ($urandom % 4) != 0;
            rt_dsc_if.data_out_rdy = ($urandom % 4) != 0;
            tick();
            guard++;
        end
        rt_scr_if.data_in_en   = 1'b0;
        rt_dsc_if.data_out_rdy = 1'b1;
        guard = 0;
        while (rt_q.size() > 0 && guard < 100) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        check("rt_count", 32'(rt_rcv), 32'(beats));
    endtask

    logic [7:0] hold_d;
    logic [6:0] hold_s;

    initial begin
        chk_en = 1'b0;
        kill = 1'b1;
        rt_kill = 1'b1;
        dut_if.scr_en = 1'b1;     dut_if.scr_mode = 2'b00;
        dut_if.init_val = 7'h00;  dut_if.init_val_en = 1'b0;
        dut_if.data_in = 8'h00;   dut_if.data_in_en = 1'b0;
        dut_if.data_out_rdy = 1'b1;
        rt_scr_if.scr_en = 1'b1;  rt_scr_if.scr_mode = 2'b01;
        rt_scr_if.init_val = 7'h7F; rt_scr_if.init_val_en = 1'b0;
        rt_scr_if.data_in = 8'h00; rt_scr_if.data_in_en = 1'b0;
        rt_dsc_if.scr_en = 1'b1;  rt_dsc_if.scr_mode = 2'b10;
        rt_dsc_if.init_val = 7'h7F; rt_dsc_if.init_val_en = 1'b0;
        rt_dsc_if.data_out_rdy = 1'b1;
        repeat (2) tick();
        kill = 1'b0;
        rt_kill = 1'b0;
        chk_en = 1'b1;

        check("rst_data_out", 32'(dut_if.data_out), 32'h00);
        check("rst_data_out_en", 32'(dut_if.data_out_en), 32'h0);
        check("rst_scr_state", 32'(dut_if.scr_state), 32'h7F);
        check("rst_data_in_rdy", 32'(dut_if.data_in_rdy), 32'h1);

        // additive keystream from the all-ones seed
        dut_if.init_val = 7'h7F; dut_if.init_val_en = 1'b1;
        tick();
        dut_if.init_val_en = 1'b0;
        check("seed_load", 32'(dut_if.scr_state), 32'h7F);
        dut_if.data_in = 8'h00; dut_if.data_in_en = 1'b1;
        tick();
        check("ks_beat0_data", 32'(dut_if.data_out), 32'h40);
        check("ks_beat0_en", 32'(dut_if.data_out_en), 32'h1);
        check("ks_beat0_state", 32'(dut_if.scr_state), 32'h02);
        tick();
        check("ks_beat1_data", 32'(dut_if.data_out), 32'h30);
        check("ks_beat1_state", 32'(dut_if.scr_state), 32'h0C);
        dut_if.data_in_en = 1'b0;

        // zero-seed guard only in additive mode
        dut_if.init_val = 7'h00; dut_if.init_val_en = 1'b1; dut_if.scr_mode = 2'b00;
        tick();
        check("zseed_add", 32'(dut_if.scr_state), 32'h7F);
        dut_if.scr_mode = 2'b01;
        tick();
        check("zseed_mul", 32'(dut_if.scr_state), 32'h00);

        // seed load together with an accept, then bypass
        dut_if.scr_mode = 2'b00; dut_if.init_val = 7'h7F;
        dut_if.data_in = 8'h00;  dut_if.data_in_en = 1'b1;
        tick();
        check("seedacc_data", 32'(dut_if.data_out), 32'h40);
        check("seedacc_state", 32'(dut_if.scr_state), 32'h02);
        dut_if.init_val_en = 1'b0; dut_if.scr_en = 1'b0; dut_if.data_in = 8'hA5;
        tick();
        check("bypass_data", 32'(dut_if.data_out), 32'hA5);
        check("bypass_state", 32'(dut_if.scr_state), 32'h02);

        // backpressure: three stalled cycles with a beat pending
        dut_if.scr_en = 1'b1; dut_if.data_in = 8'h11;
        tick();
        hold_d = dut_if.data_out;
        hold_s = dut_if.scr_state;
        dut_if.data_out_rdy = 1'b0; dut_if.data_in = 8'h22;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_data", 32'(dut_if.data_out), 32'(hold_d));
            check("stall_rdy", 32'(dut_if.data_in_rdy), 32'h0);
            check("stall_state", 32'(dut_if.scr_state), 32'(hold_s));
        end
        dut_if.data_out_rdy = 1'b1;
        tick();
        dut_if.data_in = 8'h33;
        tick();
        dut_if.data_in_en = 1'b0;
        tick();

        // randomized traffic, including mid-stream kills and mode changes
        for (int c = 0; c < 1500; c++) begin
            kill                = ($urandom % 64) == 0;
            dut_if.scr_en       = ($urandom % 8) != 0;
            dut_if.scr_mode     = 2'($urandom);
            dut_if.init_val     = (($urandom % 4) == 0) ? 7'h00 : 7'($urandom);
            dut_if.init_val_en  = ($urandom % 16) == 0;
            dut_if.data_in      = 8'($urandom);
            dut_if.data_in_en   = ($urandom % 4) != 0;
            dut_if.data_out_rdy = ($urandom % 3) != 0;
            tick();
        end
        kill = 1'b0;
        dut_if.data_in_en = 1'b0;
        dut_if.init_val_en = 1'b0;

        // round trip with matched seeds
        rt_scr_if.init_val = 7'h7F; rt_scr_if.init_val_en = 1'b1;
        rt_dsc_if.init_val = 7'h7F; rt_dsc_if.init_val_en = 1'b1;
        tick();
        rt_scr_if.init_val_en = 1'b0; rt_dsc_if.init_val_en = 1'b0;
        rt_skip = 0;
        rt_run(256);

        // self-synchronisation from a mismatched descrambler seed
        rt_scr_if.init_val = 7'h7F; rt_scr_if.init_val_en = 1'b1;
        rt_dsc_if.init_val = 7'h15; rt_dsc_if.init_val_en = 1'b1;
        tick();
        rt_scr_if.init_val_en = 1'b0; rt_dsc_if.init_val_en = 1'b0;
        rt_skip = 1;
        rt_run(64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
